// File: rtl/cdc_command_scheduler.sv
// Round-robin arbiter that serialises multi-bit commands onto a toggle-handshake bus
// crossing into another clock domain: latch, hold for setup, flip toggle, await mirrored ack.
module cdc_command_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic [DATA_WIDTH-1:0]         busData,
    output logic                          busToggle,
    input  logic                          ackToggle,
    input  logic                          clearError,
    output logic                          busy,
    output logic [IDX_W-1:0]              lastGrant,
    output logic                          timeoutError
);

    localparam int SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, ERROR} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [SET_W-1:0] setup_cnt_reg;
    logic [TO_W-1:0]  timeout_cnt_reg;

    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   scan_idx;
    logic [IDX_W-1:0] ptr_next;
    logic             any_req;
    logic             timeout_hit;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        any_req   = |reqValid;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            if (reqValid[scan_idx[IDX_W-1:0]])
                grant_idx = scan_idx[IDX_W-1:0];
        end
    end

    assign ptr_next    = (lastGrant == IDX_W'(NUM_REQ - 1)) ? '0 : lastGrant + IDX_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign busy        = (state_reg != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            setup_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            reqReady        <= '0;
            busData         <= '0;
            busToggle       <= 1'b0;
            lastGrant       <= '0;
            timeoutError    <= 1'b0;
        end else begin
            reqReady <= '0;
            if (clearError)
                timeoutError <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        busData       <= reqData[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                        lastGrant     <= grant_idx;
                        reqReady      <= NUM_REQ'(1) << grant_idx;
                        setup_cnt_reg <= '0;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt_reg == SET_W'(SETUP_CYCLES - 1)) begin
                        busToggle       <= ~busToggle;
                        timeout_cnt_reg <= '0;
                        state_reg       <= WAIT_ACK;
                    end else begin
                        setup_cnt_reg <= setup_cnt_reg + SET_W'(1);
                    end
                end
                WAIT_ACK: begin
                    // A matching ack wins over a coincident timeout.
                    if (ackToggle == busToggle) begin
                        rr_ptr_reg <= ptr_next;
                        state_reg  <= IDLE;
                    end else if (timeout_hit) begin
                        timeoutError <= 1'b1;
                        state_reg    <= ERROR;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
                    end
                end
                ERROR: begin
                    if (clearError) begin
                        rr_ptr_reg <= ptr_next;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_command_scheduler.sv
// Directed bench: cycle table for single/skip/timeout transfers, hand sequences for
// async reset, round robin with delayed ack loopback, and ack/timeout coincidence.
module tb_cdc_command_scheduler;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic [31:0] bus_data;
    logic        bus_toggle;
    logic        ack_toggle;
    logic        ack_drv;
    logic        loop_en;
    logic        clear_error;
    logic        busy;
    logic [1:0]  last_grant;
    logic        timeout_error;
    logic [2:0]  ack_pipe = 3'b000;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign req_data   = {D3, D2, D1, D0};
    assign ack_toggle = loop_en ? ack_pipe[2] : ack_drv;

    always @(posedge clock) ack_pipe <= {ack_pipe[1:0], bus_toggle};

    cdc_command_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(32), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .reqValid(req_valid), .reqData(req_data),
        .reqReady(req_ready), .busData(bus_data), .busToggle(bus_toggle),
        .ackToggle(ack_toggle), .clearError(clear_error), .busy(busy),
        .lastGrant(last_grant), .timeoutError(timeout_error)
    );

    typedef struct {
        logic [3:0]  rv;
        logic        ack;
        logic        clr;
        logic [3:0]  e_rr;
        logic [31:0] e_bd;
        logic        e_bt;
        logic        e_busy;
        logic [1:0]  e_lg;
        logic        e_te;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic [3:0] rv, input logic ack, input logic clr,
                           input logic [3:0] rr, input logic [31:0] bd, input logic bt,
                           input logic bs, input logic [1:0] lg, input logic te);
        vec_t v;
        v.rv = rv; v.ack = ack; v.clr = clr; v.e_rr = rr; v.e_bd = bd;
        v.e_bt = bt; v.e_busy = bs; v.e_lg = lg; v.e_te = te;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] dvals [4];
    int          n_grants;
    int          cur;
    int          stable_bad;
    int          budget;

    initial begin
        dvals[0] = D0; dvals[1] = D1; dvals[2] = D2; dvals[3] = D3;
        reset = 1'b1; req_valid = '0; ack_drv = 1'b0; clear_error = 1'b0; loop_en = 1'b0;

        // cycle table: single transfer, skip to req3, timeout/clear, skip after clear
        add_row(4'b0010, 0, 0, 4'b0000, 32'h0, 0, 0, 2'd0, 0);
        add_row(4'b0000, 0, 0, 4'b0010, D1,    0, 1, 2'd1, 0);
        add_row(4'b0000, 0, 0, 4'b0000, D1,    0, 1, 2'd1, 0);
        add_row(4'b0000, 0, 0, 4'b0000, D1,    1, 1, 2'd1, 0);
        add_row(4'b0000, 0, 0, 4'b0000, D1,    1, 1, 2'd1, 0);
        add_row(4'b0000, 0, 0, 4'b0000, D1,    1, 1, 2'd1, 0);
        add_row(4'b0000, 1, 0, 4'b0000, D1,    1, 1, 2'd1, 0);
        add_row(4'b1001, 1, 0, 4'b0000, D1,    1, 0, 2'd1, 0);
        add_row(4'b0001, 1, 0, 4'b1000, D3,    1, 1, 2'd3, 0);
        add_row(4'b0001, 1, 0, 4'b0000, D3,    1, 1, 2'd3, 0);
        add_row(4'b0001, 1, 0, 4'b0000, D3,    0, 1, 2'd3, 0);
        add_row(4'b0001, 0, 0, 4'b0000, D3,    0, 1, 2'd3, 0);
        add_row(4'b0001, 0, 0, 4'b0000, D3,    0, 0, 2'd3, 0);
        add_row(4'b0000, 0, 0, 4'b0001, D0,    0, 1, 2'd0, 0);
        add_row(4'b0000, 0, 0, 4'b0000, D0,    0, 1, 2'd0, 0);
        for (int i = 0; i < 8; i++)
            add_row(4'b0000, 0, 0, 4'b0000, D0, 1, 1, 2'd0, 0);
        add_row(4'b0000, 0, 0, 4'b0000, D0,    1, 1, 2'd0, 1);
        add_row(4'b0000, 0, 1, 4'b0000, D0,    1, 1, 2'd0, 1);
        add_row(4'b1001, 0, 0, 4'b0000, D0,    1, 0, 2'd0, 0);
        add_row(4'b0001, 0, 0, 4'b1000, D3,    1, 1, 2'd3, 0);
        add_row(4'b0001, 0, 0, 4'b0000, D3,    1, 1, 2'd3, 0);
        add_row(4'b0001, 0, 0, 4'b0000, D3,    0, 1, 2'd3, 0);
        add_row(4'b0001, 0, 0, 4'b0000, D3,    0, 0, 2'd3, 0);
        add_row(4'b0000, 0, 0, 4'b0001, D0,    0, 1, 2'd0, 0);

        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int c = 0; c < tbl.size(); c++) begin
            tick();
            req_valid = tbl[c].rv; ack_drv = tbl[c].ack; clear_error = tbl[c].clr;
            chk($sformatf("c%0d reqReady", c), 32'(req_ready), 32'(tbl[c].e_rr));
            chk($sformatf("c%0d busData", c), bus_data, tbl[c].e_bd);
            chk($sformatf("c%0d busToggle", c), 32'(bus_toggle), 32'(tbl[c].e_bt));
            chk($sformatf("c%0d busy", c), 32'(busy), 32'(tbl[c].e_busy));
            chk($sformatf("c%0d lastGrant", c), 32'(last_grant), 32'(tbl[c].e_lg));
            chk($sformatf("c%0d timeoutError", c), 32'(timeout_error), 32'(tbl[c].e_te));
            $display("vec c%0d rv=%b ack=%b clr=%b rr=%b bd=%h bt=%b busy=%b lg=%0d te=%b",
                     c, tbl[c].rv, tbl[c].ack, tbl[c].clr, req_ready, bus_data,
                     bus_toggle, busy, last_grant, timeout_error);
        end

        // async reset in the middle of WAIT_ACK
        tick();
        tick();
        chk("pre-reset in WAIT_ACK", 32'({busy, bus_toggle}), 32'b11);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst busData", bus_data, 32'h0);
        chk("rst busToggle/busy/te", 32'({bus_toggle, busy, timeout_error}), 32'h0);
        chk("rst reqReady/lastGrant", 32'({req_ready, last_grant}), 32'h0);
        $display("reset asserted mid-transfer bd=%h bt=%b busy=%b", bus_data, bus_toggle, busy);
        req_valid = 4'b1111;
        loop_en   = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("first grant after reset", 32'(req_ready), 32'b0001);
        chk("first grant data", bus_data, D0);
        $display("grant 0 after reset rr=%b bd=%h", req_ready, bus_data);

        // round robin with all requesters held and a 3-cycle ack loopback
        n_grants = 1; cur = 0; stable_bad = 0; budget = 0;
        while (n_grants < 5 && budget < 300) begin
            tick();
            budget++;
            if (req_ready != 4'b0000) begin
                cur = n_grants % 4;
                chk($sformatf("rr grant %0d", n_grants), 32'(req_ready), 32'(4'b0001 << cur));
                chk($sformatf("rr data %0d", n_grants), bus_data, dvals[cur]);
                chk($sformatf("rr lastGrant %0d", n_grants), 32'(last_grant), 32'(cur));
                $display("rr grant #%0d idx=%0d bd=%h", n_grants, last_grant, bus_data);
                n_grants++;
                if (n_grants == 5) req_valid = 4'b0000;
            end else if (bus_data !== dvals[cur]) begin
                stable_bad++;
            end
        end
        chk("rr grant count within budget", 32'(n_grants), 32'd5);
        chk("rr busData stable until ack", 32'(stable_bad), 32'd0);

        budget = 0;
        while (busy && budget < 100) begin
            tick();
            budget++;
        end
        chk("rr drains to idle", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("busToggle after 5 transfers", 32'(bus_toggle), 32'd1);
        ack_drv = bus_toggle;
        loop_en = 1'b0;

        // ack match lands on the last counted WAIT_ACK cycle
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        chk("coincide grant", 32'(req_ready), 32'b0100);
        for (int i = 2; i <= 10; i++) tick();
        chk("coincide still waiting", 32'({busy, bus_toggle, timeout_error}), 32'b100);
        ack_drv = 1'b0;
        tick();
        chk("coincide busy", 32'(busy), 32'd0);
        chk("coincide timeoutError", 32'(timeout_error), 32'd0);
        tick();
        chk("coincide stays clean", 32'({busy, timeout_error}), 32'd0);
        $display("coincide ack at last wait cycle busy=%b te=%b", busy, timeout_error);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
